// File: rtl/reg_alu_mc.sv
// rtl/reg_alu_mc.sv - register file + 8-op ALU with multi-cycle shift-add MUL.
// Optional REG_ALU_MC_R0_ZERO_EN: register 0 hard-wired to zero, writes to it dropped.
module reg_alu_mc #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sel,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  d_out_a,
  output logic [WIDTH-1:0]  d_out_b,
  output logic              cout,
  output logic              zero,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_regs [DEPTH];
  logic [2*WIDTH-1:0]  r_mul_a;
  logic [WIDTH-1:0]    r_mul_b;
  logic [ADDR_W-1:0]   r_mul_dst;
  logic [2*WIDTH-1:0]  r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_cout;
  logic                r_zero;
  logic                r_wb_valid;
  logic [ADDR_W-1:0]   r_wb_addr;

  logic [WIDTH-1:0]    w_a;
  logic [WIDTH-1:0]    w_b;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH-1:0]    w_alu_res;
  logic                w_alu_cout;
  logic                w_accept;
  logic                w_mul_start;
  logic                w_mul_done;
  logic [2*WIDTH-1:0]  w_acc_nxt;
  logic                w_wr_en;
  logic                w_wr_ok;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [WIDTH-1:0]    w_wr_data;
  logic                w_flag_en;
  logic                w_cout_nxt;
  logic                w_zero_nxt;

  assign w_a         = r_regs[rd_addr_a];
  assign w_b         = r_regs[rd_addr_b];
  assign w_accept    = in_valid & in_ready;
  assign w_mul_start = w_accept & sel & (op == OP_MUL);
  assign w_mul_done  = (r_state == S_MUL) && (r_cnt == LAST_STEP);
  assign w_acc_nxt   = r_acc + (r_mul_b[0] ? r_mul_a : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_mul_start) w_state_nxt = S_MUL;
      S_MUL:  if (w_mul_done)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_IDLE);
  end

  always_comb begin
    w_sum      = '0;
    w_alu_res  = '0;
    w_alu_cout = 1'b0;
    case (op)
      OP_ADD: begin
        w_sum      = {1'b0, w_a} + {1'b0, w_b};
        w_alu_res  = w_sum[WIDTH-1:0];
        w_alu_cout = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_sum      = {1'b0, w_a} + {1'b0, ~w_b} + (WIDTH+1)'(1);
        w_alu_res  = w_sum[WIDTH-1:0];
        w_alu_cout = w_sum[WIDTH];
      end
      OP_AND: w_alu_res = w_a & w_b;
      OP_OR:  w_alu_res = w_a | w_b;
      OP_XOR: w_alu_res = w_a ^ w_b;
      OP_SHL: begin
        w_alu_res  = {w_a[WIDTH-2:0], 1'b0};
        w_alu_cout = w_a[WIDTH-1];
      end
      OP_SHR: begin
        w_alu_res  = {1'b0, w_a[WIDTH-1:1]};
        w_alu_cout = w_a[0];
      end
      default: begin
        w_alu_res  = '0;
        w_alu_cout = 1'b0;
      end
    endcase
  end

  // Single write port shared by loads, single-cycle ALU ops and the MUL finish.
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_addr  = wr_addr;
    w_wr_data  = d_in;
    w_flag_en  = 1'b0;
    w_cout_nxt = r_cout;
    w_zero_nxt = r_zero;
    if (w_accept) begin
      if (!sel) begin
        w_wr_en = 1'b1;
      end else if (op != OP_MUL) begin
        w_wr_en    = 1'b1;
        w_wr_data  = w_alu_res;
        w_flag_en  = 1'b1;
        w_cout_nxt = w_alu_cout;
        w_zero_nxt = (w_alu_res == '0);
      end
    end else if (w_mul_done) begin
      w_wr_en    = 1'b1;
      w_wr_addr  = r_mul_dst;
      w_wr_data  = w_acc_nxt[WIDTH-1:0];
      w_flag_en  = 1'b1;
      w_cout_nxt = |w_acc_nxt[2*WIDTH-1:WIDTH];
      w_zero_nxt = (w_acc_nxt[WIDTH-1:0] == '0);
    end
  end

`ifdef REG_ALU_MC_R0_ZERO_EN
  assign w_wr_ok = w_wr_en && (w_wr_addr != '0);
  assign d_out_a = (rd_addr_a == '0) ? '0 : w_a;
  assign d_out_b = (rd_addr_b == '0) ? '0 : w_b;
`else
  assign w_wr_ok = w_wr_en;
  assign d_out_a = w_a;
  assign d_out_b = w_b;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_cout     <= 1'b0;
      r_zero     <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
    end else begin
      if (w_wr_ok) r_regs[w_wr_addr] <= w_wr_data;
      if (w_flag_en) begin
        r_cout <= w_cout_nxt;
        r_zero <= w_zero_nxt;
      end
      r_wb_valid <= w_wr_ok;
      if (w_wr_ok) r_wb_addr <= w_wr_addr;
    end
  end

  // Multiplicand shifts left and multiplier right so each step only tests bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_mul_dst <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else if (w_mul_start) begin
      r_mul_a   <= {{WIDTH{1'b0}}, w_a};
      r_mul_b   <= w_b;
      r_mul_dst <= wr_addr;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else if (r_state == S_MUL) begin
      r_acc   <= w_acc_nxt;
      r_mul_a <= {r_mul_a[2*WIDTH-2:0], 1'b0};
      r_mul_b <= {1'b0, r_mul_b[WIDTH-1:1]};
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign cout     = r_cout;
  assign zero     = r_zero;
  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_wb_addr;

endmodule

// File: tb/tb_reg_alu_mc.sv
// tb/tb_reg_alu_mc.sv - directed scoreboard bench for reg_alu_mc (WIDTH=16, ADDR_W=4).
module tb_reg_alu_mc;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic          sel;
  logic [2:0]    op;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  d_in;
  logic [W-1:0]  d_out_a;
  logic [W-1:0]  d_out_b;
  logic          cout;
  logic          zero;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;

  reg_alu_mc #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .op(op), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_addr(wr_addr), .d_in(d_in), .d_out_a(d_out_a), .d_out_b(d_out_b),
    .cout(cout), .zero(zero), .wb_valid(wb_valid), .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          c;
    logic          z;
  } wb_t;

  wb_t          sb_q[$];
  logic [W-1:0] m_regs [2**AW];
  logic         m_cout;
  logic         m_zero;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**AW; i++) m_regs[i] = '0;
    m_cout = 1'b0;
    m_zero = 1'b0;
    sb_q.delete();
  endtask

  task automatic issue(input logic s, input logic [2:0] o, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [AW-1:0] wr, input logic [W-1:0] din);
    int           n;
    logic [W:0]   sum;
    logic [31:0]  prod;
    logic [W-1:0] va, vb, r;
    logic         c;
    logic         allowed;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("issue_ready_timeout", 32'(in_ready), 32'(1));
    sel = s; op = o; rd_addr_a = a; rd_addr_b = b; wr_addr = wr; d_in = din;
    in_valid = 1'b1;
    va = m_regs[a];
    vb = m_regs[b];
    r  = din;
    c  = 1'b0;
    if (s) begin
      case (o)
        3'd0: begin sum = {1'b0, va} + {1'b0, vb}; r = sum[W-1:0]; c = sum[W]; end
        3'd1: begin r = va - vb; c = (va >= vb); end
        3'd2: r = va & vb;
        3'd3: r = va | vb;
        3'd4: r = va ^ vb;
        3'd5: begin r = va << 1; c = va[W-1]; end
        3'd6: begin r = va >> 1; c = va[0]; end
        default: begin prod = va * vb; r = prod[W-1:0]; c = (prod[31:16] != 0); end
      endcase
      m_cout = c;
      m_zero = (r == 0);
    end
`ifdef REG_ALU_MC_R0_ZERO_EN
    allowed = (wr != 0);
`else
    allowed = 1'b1;
`endif
    if (allowed) begin
      m_regs[wr] = r;
      sb_q.push_back('{wr, r, m_cout, m_zero});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_wb(input int budget, input string tag);
    int  n;
    wb_t e;
    n = 0;
    while (!wb_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'(1));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_wb_addr"}, 32'(wb_addr), 32'(e.addr));
      rd_addr_b = e.addr;
      #1;
      chk({tag, "_data"}, 32'(d_out_b), 32'(e.data));
      chk({tag, "_cout"}, 32'(cout), 32'(e.c));
      chk({tag, "_zero"}, 32'(zero), 32'(e.z));
    end
  endtask

  task automatic run_mul_busy(input string tag);
    int busy;
    busy = 0;
    while (!in_ready && busy < 100) begin
      busy++;
      if (busy == 3) begin
        in_valid = 1'b1; sel = 1'b0; wr_addr = 4'd9; d_in = 16'hAAAA;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(busy), 32'(W));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    reset = 1'b1; in_valid = 1'b0; sel = 1'b0; op = '0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; d_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_wb_valid", 32'(wb_valid), 32'(0));
    chk("rst_wb_addr", 32'(wb_addr), 32'(0));
    chk("rst_flags", 32'({cout, zero}), 32'(0));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    issue(1'b0, 3'd0, 4'd0, 4'd0, 4'd1, 16'hFFFF); expect_wb(0, "ld_r1");
    issue(1'b0, 3'd0, 4'd0, 4'd0, 4'd2, 16'h0001); expect_wb(0, "ld_r2");
    issue(1'b1, 3'd0, 4'd1, 4'd2, 4'd3, 16'h0000); expect_wb(0, "add_r3");
    issue(1'b1, 3'd1, 4'd2, 4'd1, 4'd4, 16'h0000); expect_wb(0, "sub_r4");
    issue(1'b1, 3'd1, 4'd1, 4'd2, 4'd5, 16'h0000); expect_wb(0, "sub_r5");
    issue(1'b1, 3'd2, 4'd1, 4'd5, 4'd10, 16'h0000); expect_wb(0, "and_r10");
    issue(1'b1, 3'd3, 4'd4, 4'd2, 4'd11, 16'h0000); expect_wb(0, "or_r11");
    issue(1'b1, 3'd4, 4'd1, 4'd1, 4'd12, 16'h0000); expect_wb(0, "xor_r12");
    issue(1'b1, 3'd5, 4'd1, 4'd0, 4'd13, 16'h0000); expect_wb(0, "shl_r13");
    issue(1'b1, 3'd6, 4'd2, 4'd0, 4'd13, 16'h0000); expect_wb(0, "shr_r13");
    issue(1'b0, 3'd0, 4'd0, 4'd0, 4'd2, 16'h1234); expect_wb(0, "ld_keep_flags");

    issue(1'b0, 3'd0, 4'd0, 4'd0, 4'd6, 16'h0123); expect_wb(0, "ld_r6");
    issue(1'b0, 3'd0, 4'd0, 4'd0, 4'd7, 16'h0010); expect_wb(0, "ld_r7");
    issue(1'b1, 3'd7, 4'd6, 4'd7, 4'd8, 16'h0000);
    rd_addr_a = 4'd8;
    #1;
    chk("mul_no_early_write", 32'(d_out_a), 32'(0));
    run_mul_busy("mul1");
    expect_wb(0, "mul1");
    rd_addr_b = 4'd9;
    #1;
    chk("busy_issue_ignored", 32'(d_out_b), 32'(m_regs[9]));
    @(posedge clk); #1;
    chk("mul1_single_pulse", 32'(wb_valid), 32'(0));

    issue(1'b0, 3'd0, 4'd0, 4'd0, 4'd6, 16'h8000); expect_wb(0, "ld_r6b");
    issue(1'b0, 3'd0, 4'd0, 4'd0, 4'd7, 16'h0002); expect_wb(0, "ld_r7b");
    issue(1'b1, 3'd7, 4'd6, 4'd7, 4'd14, 16'h0000);
    run_mul_busy("mul2");
    expect_wb(0, "mul2");

    issue(1'b1, 3'd7, 4'd6, 4'd7, 4'd15, 16'h0000);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #1 reset = 1'b1;
    #1;
    chk("amid_in_ready", 32'(in_ready), 32'(1));
    chk("amid_wb_valid", 32'(wb_valid), 32'(0));
    chk("amid_flags", 32'({cout, zero}), 32'(0));
    bad = 0;
    for (int i = 0; i < 2**AW; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(i);
      #1;
      if (d_out_a !== '0 || d_out_b !== '0) bad++;
    end
    chk("amid_regs_zero", 32'(bad), 32'(0));
    model_reset();
    @(negedge clk) reset = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    chk("amid_no_writeback", 32'(wb_valid), 32'(0));
    rd_addr_a = 4'd15;
    #1;
    chk("amid_r15", 32'(d_out_a), 32'(0));

    issue(1'b0, 3'd0, 4'd0, 4'd0, 4'd1, 16'h0005); expect_wb(0, "ld_r1_5");
    issue(1'b1, 3'd0, 4'd1, 4'd1, 4'd1, 16'h0000); expect_wb(0, "rmw1");
    issue(1'b1, 3'd0, 4'd1, 4'd1, 4'd1, 16'h0000); expect_wb(0, "rmw2");

    issue(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 16'h1234);
`ifdef REG_ALU_MC_R0_ZERO_EN
    rd_addr_a = 4'd0;
    #1;
    chk("r0_reads_zero", 32'(d_out_a), 32'(0));
    chk("r0_no_wb", 32'(wb_valid), 32'(0));
    issue(1'b1, 3'd1, 4'd1, 4'd1, 4'd0, 16'h0000);
    chk("r0_alu_zero_flag", 32'(zero), 32'(1));
    chk("r0_alu_no_wb", 32'(wb_valid), 32'(0));
`else
    expect_wb(0, "ld_r0");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
